// File: rtl/riscv_pkg.sv
// Shared types for the decode/execute boundary.
// Provides the decoded control bundle, its all-zero NOP value and the
// ID/EX stage state encoding.
package riscv_pkg;

  typedef struct packed {
    logic       RUwrite;
    logic       MemRead;
    logic       MemWrite;
    logic       ALUASrc;
    logic       ALUBSrc;
    logic [3:0] ALUOp;
    logic [1:0] RUDataWrSrc;
    logic [4:0] BrOp;
  } ctrl_t;

  // A bubble must never write the register file or memory.
  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2
  } idex_state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use detection and stall generation.
// Ports: decode-side indices/use flags, EX-side valid/MemRead/rd,
//        ex_hold/flush/rst qualifiers in; lu and stall out (no latency).
module hazard_detect (
  input  logic       rst,
  input  logic       flush,
  input  logic       ex_hold,
  input  logic       id_valid,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu,
  output logic       stall
);

  logic src_match;

  always_comb begin
    src_match = (use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2));
    // x0 is never a real dependency, even if a load targets it.
    lu        = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && src_match;
    // A flush squashes decode, so there is nothing left to hold back.
    stall     = !rst && !flush && (ex_hold || lu);
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use
// bubble insertion, hold/flush control and a saturating bubble counter.
// Ports: clk/rst; IF/ID fields + RU1/RU2 + wb_* bypass in; ex_hold/flush in;
//        stall (combinational), registered ex_* payload, bubble_count out.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [XLEN-1:0] id_imm,
  input  ctrl_t           id_ctrl,
  input  logic [XLEN-1:0] RU1,
  input  logic [XLEN-1:0] RU2,
  input  logic            wb_RUwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_RUdw,
  input  logic            ex_hold,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_RU1,
  output logic [XLEN-1:0] ex_RU2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output ctrl_t           ex_ctrl,
  output logic [CNTW-1:0] bubble_count
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            lu;
  idex_state_t     state;

  // The register file writes on the same edge this stage samples, so the
  // write-back value has to be picked up here or it would be missed.
  always_comb begin
    op_a = RU1;
    if (rs1 == 5'd0)
      op_a = '0;
    else if (wb_RUwrite && (wb_rd != 5'd0) && (wb_rd == rs1))
      op_a = wb_RUdw;

    op_b = RU2;
    if (rs2 == 5'd0)
      op_b = '0;
    else if (wb_RUwrite && (wb_rd != 5'd0) && (wb_rd == rs2))
      op_b = wb_RUdw;
  end

  hazard_detect u_hazard (
    .rst        (rst),
    .flush      (flush),
    .ex_hold    (ex_hold),
    .id_valid   (id_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .use_rs1    (use_rs1),
    .use_rs2    (use_rs2),
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_ctrl.MemRead),
    .ex_rd      (ex_rd),
    .lu         (lu),
    .stall      (stall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= NORMAL;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_RU1       <= '0;
      ex_RU2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= CTRL_NOP;
      bubble_count <= '0;
    end else if (flush) begin
      // Flush beats hold: the squashed instruction must not linger in EX.
      state        <= NORMAL;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_RU1       <= '0;
      ex_RU2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= CTRL_NOP;
    end else if (ex_hold) begin
      state        <= HOLD;
    end else if (lu) begin
      // The bubble drops ex_valid, which clears the hazard next cycle and
      // lets the stalled dependent instruction through.
      state        <= BUBBLE;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_RU1       <= '0;
      ex_RU2       <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_ctrl      <= CTRL_NOP;
      if (bubble_count != {CNTW{1'b1}})
        bubble_count <= bubble_count + 1'b1;
    end else begin
      state        <= NORMAL;
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_RU1       <= op_a;
      ex_RU2       <= op_b;
      ex_imm       <= id_imm;
      ex_rs1       <= rs1;
      ex_rs2       <= rs2;
      ex_rd        <= rd;
      ex_ctrl      <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  // A bubble state always means an empty EX slot.
  a_bubble_empty: assert property (@(posedge clk) disable iff (rst)
    (state == BUBBLE) |-> !ex_valid);

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly downstream of `ru`. It captures the IF/ID instruction fields together with the `RU1`/`RU2` read data, and applies write-back bypass for same-cycle `ru` writes. It detects load-use hazards against the instruction it currently holds and inserts bubbles. It registers everything into the ID/EX pipeline register with stall, hold and flush control, and keeps a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNTW`, 16, width of bubble counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `id_valid`  in  1  IF/ID holds a real instruction
- `id_pc`  in  XLEN  PC of the decoding instruction
- `rs1`, `rs2`, `rd`  in  5 each  register indices; `rs1`/`rs2` also drive `ru`
- `use_rs1`, `use_rs2`  in  1 each  instruction actually reads that source
- `id_imm`  in  XLEN  sign-extended immediate
- `id_ctrl`  in  `ctrl_t`  decoded control bundle
- `RU1`, `RU2`  in  XLEN  combinational read data from `ru`
- `wb_RUwrite`  in  1  write-back stage writes `ru` this cycle
- `wb_rd`  in  5  write-back destination
- `wb_RUdw`  in  XLEN  write-back data
- `ex_hold`  in  1  EX cannot accept a new instruction
- `flush`  in  1  squash the instruction in decode (taken branch/jump)
- `stall`  out  1  IF and IF/ID must hold their contents
- `ex_valid`  out  1  ID/EX holds a real instruction
- `ex_pc`, `ex_RU1`, `ex_RU2`, `ex_imm`  out  XLEN each  registered payload
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  registered indices for EX forwarding
- `ex_ctrl`  out  `ctrl_t`  registered control
- `bubble_count`  out  CNTW  saturating count of inserted load-use bubbles

## Operation
- Operand select for `opA` (same rule for `opB` using `rs2`/`RU2`):
  - `rs1==0` → 0.
  - Otherwise, `wb_RUwrite && wb_rd!=0 && wb_rd==rs1` → `wb_RUdw`.
  - Otherwise → `RU1`.
- Load-use hazard `lu`: `id_valid && ex_valid && ex_ctrl.MemRead && ex_rd!=0 && ((use_rs1 && ex_rd==rs1) || (use_rs2 && ex_rd==rs2))`.
- Per-edge action. The highest-priority true condition wins:
  1. `rst`: `ex_valid=0`, all payload, `ex_ctrl` and `bubble_count` = 0.
  2. `flush`: load a bubble (`ex_valid=0`, `ex_ctrl=CTRL_NOP`, payload = 0).
  3. `ex_hold`: all ID/EX registers keep their value.
  4. `lu`: load a bubble. `bubble_count` increments, saturating at all-ones.
  5. Otherwise: load `id_valid`, `id_pc`, `opA`, `opB`, `id_imm`, `rs1`, `rs2`, `rd`, `id_ctrl`.
- If `id_valid=0` in case 5, then `ex_ctrl=CTRL_NOP`, so a bubble never carries `RUwrite`/`MemWrite`.
- `stall = !flush && (ex_hold || lu)`. `stall` is combinational. It is 0 during `rst`.
- State machine: `NORMAL`, `HOLD`, `BUBBLE`.
  - `NORMAL` → `BUBBLE` on `lu`. `BUBBLE` → `NORMAL` next cycle. The hazard clears because `ex_valid=0`.
  - Any state → `HOLD` while `ex_hold`. `HOLD` → `NORMAL` when `ex_hold` drops.
  - `flush` → `NORMAL`.
  - The state is exposed only through `stall`. It is kept for assertions and debug.

## Timing
- ID/EX latency: 1 cycle from decode inputs to `ex_*`.
- Bypass covers `ru` writes that land on the same edge the decode reads. `ru` writes on the rising edge when `RUwrite` is high.
- A load-use hazard costs exactly one bubble cycle. The dependent instruction enters EX on the following edge with its sources unchanged. The load's result is then forwarded from MEM by the EX forwarding logic.
- Reset mid-hold or mid-bubble: the next edge yields the full reset values and `stall=0`.
- Simultaneous `flush` and `lu`: bubble with no count increment, and `stall=0`.
- Simultaneous `flush` and `ex_hold`: the flush wins and the bubble is loaded. The EX owner must tolerate this.

## Structure
- Package `riscv_pkg`:
  - `ctrl_t` packed struct: `RUwrite`, `MemRead`, `MemWrite`, `ALUASrc`, `ALUBSrc`, `ALUOp[3:0]`, `RUDataWrSrc[1:0]`, `BrOp[4:0]`.
  - Constant `CTRL_NOP` (all zero).
  - State enum `idex_state_t`.
- One sub-module, `hazard_detect`, contains the combinational `lu` and `stall` logic. The pipeline register and counter stay in `id_ex_stage`.

## Test plan
- Reset → hold `rst=1` for 2 cycles with random inputs → all `ex_*` = 0, `ex_valid=0`, `stall=0`, `bubble_count=0`.
- Plain pass-through → `rs1=21`, `RU1=32'hAAAAAA95`, `id_imm=32'h10`, `id_valid=1` → next cycle `ex_RU1=32'hAAAAAA95`, `ex_rs1=21`, `ex_imm=32'h10`, `ex_valid=1`.
- WB bypass → `rs2=18`, `RU2=0`, `wb_RUwrite=1`, `wb_rd=18`, `wb_RUdw=32'hF565FA95` → `ex_RU2=32'hF565FA95`; repeat with `wb_rd=0` → `ex_RU2=0`.
- Load-use → EX holds load (`MemRead=1`, `ex_rd=5`), decode `rs1=5`, `use_rs1=1` → `stall=1` for one cycle, next `ex_valid=0`, then the dependent instruction enters with `bubble_count=1`; same case with `use_rs1=0` → no stall.
- Flush priority → `lu` true plus `flush=1` → `stall=0`, bubble loaded, `bubble_count` unchanged.
- Hold → `ex_hold=1` for 3 cycles → `ex_*` frozen and `stall=1` throughout; release → next decode instruction loads on the following edge.
